// File: rtl/f3m_pkg.sv
// rtl/f3m_pkg.sv - shared constants, mode codes and FSM states for the GF(3^M) scalar MAC
package f3m_pkg;
    localparam int M = 97;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;

    typedef enum logic [1:0] {
        MODE_SCALE = 2'd0,
        MODE_ADD   = 2'd1,
        MODE_SUB   = 2'd2,
        MODE_NEG   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/f3_mac_trit.sv
// rtl/f3_mac_trit.sv - combinational single-trit r = b +/- k*a over GF(3)
module f3_mac_trit
    import f3m_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] k,
    input  logic       neg,
    input  logic       noadd,
    output logic [1:0] r
);
    // The unused code 11 is folded to zero on every input.
    function automatic logic [1:0] norm(input logic [1:0] t);
        return (t == 2'b11) ? T0 : t;
    endfunction

    logic [1:0] an, bn, kn, p, pn;
    logic [2:0] s, sm;

    always_comb begin
        an = norm(a);
        bn = norm(b);
        kn = norm(k);
        if (kn == T0 || an == T0) p = T0;
        else if (kn == an)        p = T1;
        else                      p = T2;
        if (neg) pn = (p == T0) ? T0 : ((p == T1) ? T2 : T1);
        else     pn = p;
        s  = {1'b0, bn} + {1'b0, pn};
        sm = s - 3'd3;
        if (noadd)          r = pn;
        else if (s > 3'd2)  r = sm[1:0];
        else                r = s[1:0];
    end
endmodule

// File: rtl/f3m_scalar_mac.sv
// rtl/f3m_scalar_mac.sv - digit-serial GF(3^M) c = b + s*(k*a) with start/done handshake
module f3m_scalar_mac #(
    parameter int M = f3m_pkg::M,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*M-1:0] a,
    input  logic [2*M-1:0] b,
    input  logic [1:0]     k,
    input  logic [1:0]     mode,
    output logic           busy,
    output logic           done,
    output logic [2*M-1:0] c
);
    import f3m_pkg::*;

    localparam int NCYC = (M + D - 1) / D;
    localparam int CW   = $clog2(NCYC + 1);
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    state_t         state;
    mode_t          mode_q;
    logic [2*M-1:0] a_q, b_q, res;
    logic [1:0]     k_q;
    logic [CW-1:0]  cnt;
    logic [2*D-1:0] r_dig;
    logic           neg, noadd, accept;

    assign neg    = (mode_q == MODE_SUB)   || (mode_q == MODE_NEG);
    assign noadd  = (mode_q == MODE_SCALE) || (mode_q == MODE_NEG);
    // DONE counts as idle for acceptance so operations can run back to back.
    assign accept = start && (state == IDLE || state == DONE);

    for (genvar j = 0; j < D; j++) begin : g_lane
        int         idx;
        logic [1:0] a_t, b_t, r_t;
        assign idx = int'(cnt) * D + j;
        assign a_t = (idx < M) ? a_q[2*idx +: 2] : T0;
        assign b_t = (idx < M) ? b_q[2*idx +: 2] : T0;
        f3_mac_trit u_trit (
            .a     (a_t),
            .b     (b_t),
            .k     (k_q),
            .neg   (neg),
            .noadd (noadd),
            .r     (r_t)
        );
        assign r_dig[2*j +: 2] = r_t;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            c      <= '0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            mode_q <= MODE_SCALE;
            res    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                RUN: begin
                    // Lanes past the last trit of a partial final digit are dropped.
                    for (int j = 0; j < D; j++) begin
                        if (int'(cnt) * D + j < M)
                            res[2*(int'(cnt) * D + j) +: 2] <= r_dig[2*j +: 2];
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    c     <= res;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                k_q    <= k;
                mode_q <= mode_t'(mode);
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_f3m_scalar_mac.sv
// tb/tb_f3m_scalar_mac.sv - scoreboard bench for f3m_scalar_mac against a mod-3 reference model
module tb_f3m_scalar_mac;
    localparam int M    = 97;
    localparam int D    = 8;
    localparam int NCYC = (M + D - 1) / D;
    localparam int W    = 2 * M;

    logic         clk, reset, start, busy, done;
    logic [W-1:0] a, b, c;
    logic [1:0]   k, mode;

    f3m_scalar_mac #(.M(M), .D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .k     (k),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: every trit independently, plain integer arithmetic mod 3.
    function automatic logic [W-1:0] ref_mac(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic [1:0] kv, input logic [1:0] mv);
        logic [W-1:0] out;
        int ai, bi, ki, p, r;
        out = '0;
        ki = (kv == 2'b11) ? 0 : int'(kv);
        for (int i = 0; i < M; i++) begin
            ai = int'(av[2*i +: 2]);
            bi = int'(bv[2*i +: 2]);
            if (ai == 3) ai = 0;
            if (bi == 3) bi = 0;
            p = (ki * ai) % 3;
            case (mv)
                2'd0:    r = p;
                2'd1:    r = (bi + p) % 3;
                2'd2:    r = (bi - p + 3) % 3;
                default: r = (3 - p) % 3;
            endcase
            out[2*i +: 2] = 2'(r);
        end
        return out;
    endfunction

    function automatic logic [W-1:0] rep(input logic [1:0] t);
        logic [W-1:0] v;
        for (int i = 0; i < M; i++) v[2*i +: 2] = t;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] v;
        for (int i = 0; i < M; i++) v[2*i +: 2] = 2'($urandom_range(0, 3));
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk_vec("result", c, e.val);
                chk_int("latency", cyc, e.due);
            end
        end
    end

    // Called at posedge+1; start is sampled at the next edge, then inputs are scrambled.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [1:0] kv, input logic [1:0] mv, input bit push);
        exp_t x;
        a = av; b = bv; k = kv; mode = mv; start = 1'b1;
        if (push) begin
            x.val = ref_mac(av, bv, kv, mv);
            x.due = cyc + NCYC + 2;
            q.push_back(x);
        end
        @(posedge clk); #1;
        start = 1'b0;
        a = rand_elem(); b = rand_elem();
        k = 2'($urandom_range(0, 3)); mode = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !busy && !done) return;
            @(posedge clk); #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL idle_timeout: got %0d pending expected 0", q.size());
    endtask

    logic [W-1:0] ta, tb_v;
    int bc, dc;
    bit seen;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; k = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_vec("reset_c", c, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // SCALE k=2 on all-ones, with busy-width measurement
        issue(rep(2'b01), rand_elem(), 2'd2, 2'd0, 1'b1);
        bc = busy ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
            if (busy) bc++;
        end
        chk_int("scale_done_seen", int'(seen), 1);
        chk_int("busy_width", bc, NCYC);
        chk_vec("scale_all2", c, rep(2'b10));
        wait_idle();

        issue(rep(2'b10), rep(2'b10), 2'd1, 2'd1, 1'b1);
        wait_idle();
        issue(rep(2'b10), rep(2'b10), 2'd1, 2'd2, 1'b1);
        wait_idle();

        // NEG hitting trit 0 and the lone trit of the last partial digit
        ta = '0; ta[1:0] = 2'b01; ta[2*96 +: 2] = 2'b10;
        issue(ta, rand_elem(), 2'd1, 2'd3, 1'b1);
        wait_idle();

        issue(rep(2'b11), rep(2'b11), 2'd1, 2'd1, 1'b1);
        wait_idle();
        issue(rand_elem(), rep(2'b01), 2'b11, 2'd2, 1'b1);
        wait_idle();

        // start mid-RUN is ignored; start in DONE is accepted
        issue(rand_elem(), rand_elem(), 2'd2, 2'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a = rand_elem(); b = rand_elem(); k = 2'd1; mode = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        issue(rand_elem(), rand_elem(), 2'd1, 2'd2, 1'b1);
        wait_idle();

        // reset in the middle of RUN
        issue(rep(2'b01), rep(2'b01), 2'd1, 2'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_done", int'(done), 0);
        chk_vec("abort_c", c, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        dc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        chk_int("abort_no_done", dc, 0);

        for (int n = 0; n < 25; n++) begin
            ta = rand_elem();
            tb_v = rand_elem();
            issue(ta, tb_v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
            wait_idle();
        end

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
